exwb_pipe_buf: RTL and testbench
================================

# exwb_pipe_buf

Parametrised execute-to-writeback pipeline buffer, the next generation of the fixed two-deep EX/WB register. It carries the DMEM read data, ALU result, immediate, destination register, writeback control word and N/Z flags through a configurable number of register stages. It adds a valid bit, stall/flush control, bubble insertion and a combinational forwarding lookup across all in-flight stages. It sits between the EX/MEM stage and the register-file write port.

## Interface
Parameters:
- DATA_W, 32, width of DMEM, ALU and I fields
- RD_W, 6, destination register index width
- WB_W, 7, writeback control word width
- DEPTH, 2, number of register stages (input-to-output latency); legal range 1..8
- REGWRITE_BIT, 0, index in WB of the register-write enable
- MEMTOREG_BIT, 1, index in WB selecting DMEM (1) or ALU (0) as writeback data

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold every stage this cycle
- flush  in  1  invalidate every stage this cycle
- iValid  in  1  input payload is a real instruction
- iDMEM, iALU, iI  in  DATA_W  payload data
- iRd  in  RD_W  destination register
- iWB  in  WB_W  writeback control
- iN, iZ  in  1  flags
- oValid  out  1  output stage holds a real instruction
- oDMEM, oALU, oI  out  DATA_W  output payload
- oRd  out  RD_W; oWB  out  WB_W; oN, oZ  out  1
- qRs  in  RD_W  forwarding query register
- oFwdHit  out  1  an in-flight valid stage writes qRs
- oFwdData  out  DATA_W  value to forward on hit, else 0

## Operation
- Stage 0 is youngest; stage DEPTH-1 drives the o* ports.
- Normal cycle (stall=0, flush=0): stage k loads stage k-1; stage 0 loads inputs.
- Bubble rule: when a stage loads with valid=0, its WB field is stored as 0. Other payload fields load normally. An invalid entry therefore never writes back.
- stall=1, flush=0: all stages, including valid bits, hold.
- flush=1: all valid bits and WB fields clear on the edge, and the input is not captured. Flush overrides stall.
- reset=1: every stage field and valid bit goes to 0. Reset overrides flush and stall. Valid regardless of where data sits mid-pipeline.
- Forwarding is combinational from the stage registers:
  - candidate = valid && WB[REGWRITE_BIT] && Rd==qRs
  - youngest candidate wins (lowest stage index)
  - oFwdData = candidate's WB[MEMTOREG_BIT] ? DMEM : ALU
  - with no candidate: oFwdHit=0, oFwdData=0
  - the input port is not searched

## Timing
- Latency: a payload presented at edge t appears on outputs after edge t+DEPTH-1, i.e. it is visible during cycle t+DEPTH. Each stall cycle adds one cycle.
- Throughput: one payload per unstalled cycle.
- Reset values: oValid=0, oDMEM=oALU=oI=0, oRd=0, oWB=0, oN=oZ=0. oFwdHit=0 and oFwdData=0 after reset.
- Outputs change only on the rising edge of clock; the forwarding outputs also follow qRs combinationally.
- DEPTH=1 is a single register with the same control semantics.

## Structure
- Shared package exwb_pkg holds:
  - DATA_W/RD_W/WB_W defaults and the REGWRITE/MEMTOREG bit constants
  - a packed struct exwb_stage_t {valid, DMEM, ALU, I, Rd, WB, N, Z}
- Sub-module exwb_stage_cell: one stage register with load/hold/clear, bubble WB zeroing, and synchronous reset. The top level generates DEPTH instances and a priority forwarding mux.

## Test plan
- Reset, then DEPTH=2; drive iValid=1, iALU=0x11, iRd=5, iWB=0x01 for one cycle → oValid=1, oALU=0x11, oRd=5 two cycles after the drive edge. Outputs before that are all 0.
- Stream 4 payloads with stall=1 asserted for 2 cycles mid-stream → outputs hold the same values for 2 extra cycles; no payload is lost or duplicated.
- Fill both stages, then assert flush=1 together with stall=1 → next cycle oValid=0 and oWB=0; the input presented that cycle never appears.
- iValid=0 with iWB=0x7F → that entry reaches the output with oWB=0 and oValid=0.
- Forwarding:
  - stage0 has Rd=3, WB=0x03 (memtoreg), DMEM=0xAA
  - stage1 has Rd=3, WB=0x01, ALU=0xBB
  - with qRs=3 → oFwdHit=1, oFwdData=0xAA
  - with qRs=4 → oFwdHit=0, oFwdData=0
- Assert reset mid-stream with stall=1 → the next cycle shows every output 0 and oValid=0.

Source files
------------

// File: rtl/exwb_pkg.sv
// Shared definitions for the EX/WB pipeline buffer: default widths, writeback
// control bit positions and the stage record layout.
package exwb_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_RD_W         = 6;
  localparam int DEF_WB_W         = 7;
  localparam int DEF_DEPTH        = 2;
  localparam int DEF_REGWRITE_BIT = 0;
  localparam int DEF_MEMTOREG_BIT = 1;

  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] dmem;
    logic [DEF_DATA_W-1:0] alu;
    logic [DEF_DATA_W-1:0] i;
    logic [DEF_RD_W-1:0]   rd;
    logic [DEF_WB_W-1:0]   wb;
    logic                  n;
    logic                  z;
  } exwb_stage_t;

endpackage

// File: rtl/exwb_stage_cell.sv
// One EX/WB pipeline stage: load, hold on stall, clear valid/WB on flush.
// An entry loaded as invalid stores a zero WB word so it can never write back.
module exwb_stage_cell
  import exwb_pkg::*;
#(
  parameter int PAY_W = 1,
  parameter int WB_W  = DEF_WB_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             src_valid,
  input  logic [WB_W-1:0]  src_wb,
  input  logic [PAY_W-1:0] src_pay,
  output logic             valid,
  output logic [WB_W-1:0]  wb,
  output logic [PAY_W-1:0] pay
);

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value, which is what makes this a shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      wb    <= '0;
      pay   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      wb    <= '0;
    end else if (!stall) begin
      valid <= src_valid;
      wb    <= src_valid ? src_wb : '0;
      pay   <= src_pay;
    end
  end

endmodule

// File: rtl/exwb_pipe_buf.sv
// Parametrised EX/WB pipeline buffer: DEPTH chained stage cells plus a
// combinational forwarding lookup where the youngest matching stage wins.
module exwb_pipe_buf
  import exwb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RD_W         = DEF_RD_W,
  parameter int WB_W         = DEF_WB_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int REGWRITE_BIT = DEF_REGWRITE_BIT,
  parameter int MEMTOREG_BIT = DEF_MEMTOREG_BIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iDMEM,
  input  logic [DATA_W-1:0] iALU,
  input  logic [DATA_W-1:0] iI,
  input  logic [RD_W-1:0]   iRd,
  input  logic [WB_W-1:0]   iWB,
  input  logic              iN,
  input  logic              iZ,
  output logic              oValid,
  output logic [DATA_W-1:0] oDMEM,
  output logic [DATA_W-1:0] oALU,
  output logic [DATA_W-1:0] oI,
  output logic [RD_W-1:0]   oRd,
  output logic [WB_W-1:0]   oWB,
  output logic              oN,
  output logic              oZ,
  input  logic [RD_W-1:0]   qRs,
  output logic              oFwdHit,
  output logic [DATA_W-1:0] oFwdData
);

  // Payload layout, MSB first: {dmem, alu, i, rd, n, z}.
  localparam int PAY_W = 3 * DATA_W + RD_W + 2;

  logic             stg_valid [DEPTH];
  logic [WB_W-1:0]  stg_wb    [DEPTH];
  logic [PAY_W-1:0] stg_pay   [DEPTH];

  logic [DATA_W-1:0] fwd_dmem [DEPTH];
  logic [DATA_W-1:0] fwd_alu  [DEPTH];
  logic [RD_W-1:0]   fwd_rd   [DEPTH];

  logic [PAY_W-1:0] in_pay;
  assign in_pay = {iDMEM, iALU, iI, iRd, iN, iZ};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             src_valid;
    logic [WB_W-1:0]  src_wb;
    logic [PAY_W-1:0] src_pay;

    if (k == 0) begin : g_head
      assign src_valid = iValid;
      assign src_wb    = iWB;
      assign src_pay   = in_pay;
    end else begin : g_link
      assign src_valid = stg_valid[k-1];
      assign src_wb    = stg_wb[k-1];
      assign src_pay   = stg_pay[k-1];
    end

    exwb_stage_cell #(
      .PAY_W (PAY_W),
      .WB_W  (WB_W)
    ) u_cell (
      .clock     (clock),
      .reset     (reset),
      .stall     (stall),
      .flush     (flush),
      .src_valid (src_valid),
      .src_wb    (src_wb),
      .src_pay   (src_pay),
      .valid     (stg_valid[k]),
      .wb        (stg_wb[k]),
      .pay       (stg_pay[k])
    );

    assign fwd_dmem[k] = stg_pay[k][PAY_W-1 -: DATA_W];
    assign fwd_alu[k]  = stg_pay[k][PAY_W-DATA_W-1 -: DATA_W];
    assign fwd_rd[k]   = stg_pay[k][RD_W+1:2];
  end

  assign oValid = stg_valid[DEPTH-1];
  assign oWB    = stg_wb[DEPTH-1];
  assign {oDMEM, oALU, oI, oRd, oN, oZ} = stg_pay[DEPTH-1];

  // Scan oldest to youngest so the youngest candidate overwrites older ones.
  // NOTE: both outputs get a default first so no path leaves them unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    oFwdHit  = 1'b0;
    oFwdData = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (stg_valid[k] && stg_wb[k][REGWRITE_BIT] && (fwd_rd[k] == qRs)) begin
        oFwdHit  = 1'b1;
        oFwdData = stg_wb[k][MEMTOREG_BIT] ? fwd_dmem[k] : fwd_alu[k];
      end
    end
  end

endmodule

// File: tb/tb_exwb_pipe_buf.sv
// Directed bench for exwb_pipe_buf at DEPTH=2: a table of per-cycle vectors
// followed by hand-written latency and combinational-forwarding sequences.
module tb_exwb_pipe_buf;
  import exwb_pkg::*;

  localparam int DATA_W = 32;
  localparam int RD_W   = 6;
  localparam int WB_W   = 7;
  localparam int DEPTH  = 2;
  localparam int CMP_W  = 1 + 3 * DATA_W + RD_W + WB_W + 2 + 1 + DATA_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              iValid = 1'b0;
  logic [DATA_W-1:0] iDMEM = '0, iALU = '0, iI = '0;
  logic [RD_W-1:0]   iRd = '0;
  logic [WB_W-1:0]   iWB = '0;
  logic              iN = 1'b0, iZ = 1'b0;
  logic              oValid;
  logic [DATA_W-1:0] oDMEM, oALU, oI;
  logic [RD_W-1:0]   oRd;
  logic [WB_W-1:0]   oWB;
  logic              oN, oZ;
  logic [RD_W-1:0]   qRs = '0;
  logic              oFwdHit;
  logic [DATA_W-1:0] oFwdData;

  exwb_pipe_buf #(
    .DATA_W (DATA_W), .RD_W (RD_W), .WB_W (WB_W), .DEPTH (DEPTH),
    .REGWRITE_BIT (0), .MEMTOREG_BIT (1)
  ) dut (
    .clock (clock), .reset (reset), .stall (stall), .flush (flush),
    .iValid (iValid), .iDMEM (iDMEM), .iALU (iALU), .iI (iI), .iRd (iRd),
    .iWB (iWB), .iN (iN), .iZ (iZ),
    .oValid (oValid), .oDMEM (oDMEM), .oALU (oALU), .oI (oI), .oRd (oRd),
    .oWB (oWB), .oN (oN), .oZ (oZ),
    .qRs (qRs), .oFwdHit (oFwdHit), .oFwdData (oFwdData)
  );

  always #5 clock = ~clock;

  typedef struct {
    string             name;
    logic              rst, stl, fls, v;
    logic [DATA_W-1:0] dmem, alu;
    logic [RD_W-1:0]   rd;
    logic [WB_W-1:0]   wb;
    logic [RD_W-1:0]   qrs;
    logic              ev;
    logic [DATA_W-1:0] edmem, ealu;
    logic [RD_W-1:0]   erd;
    logic [WB_W-1:0]   ewb;
    logic              ehit;
    logic [DATA_W-1:0] efd;
  } vec_t;

  vec_t tbl [24];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic vec_t mk(string name, logic rst, logic stl, logic fls, logic v,
                              logic [DATA_W-1:0] dmem, logic [DATA_W-1:0] alu,
                              logic [RD_W-1:0] rd, logic [WB_W-1:0] wb, logic [RD_W-1:0] qrs,
                              logic ev, logic [DATA_W-1:0] edmem, logic [DATA_W-1:0] ealu,
                              logic [RD_W-1:0] erd, logic [WB_W-1:0] ewb,
                              logic ehit, logic [DATA_W-1:0] efd);
    vec_t r;
    r.name = name; r.rst = rst; r.stl = stl; r.fls = fls; r.v = v;
    r.dmem = dmem; r.alu = alu; r.rd = rd; r.wb = wb; r.qrs = qrs;
    r.ev = ev; r.edmem = edmem; r.ealu = ealu; r.erd = erd; r.ewb = ewb;
    r.ehit = ehit; r.efd = efd;
    return r;
  endfunction

  // I, N and Z are derived from ALU on the way in, so they are predicted the same way.
  function automatic logic [CMP_W-1:0] expect_of(vec_t t);
    return {t.ev, t.edmem, t.ealu, t.ealu << 4, t.erd, t.ewb, t.ealu[0], t.ealu[1],
            t.ehit, t.efd};
  endfunction

  function automatic logic [CMP_W-1:0] observed();
    exwb_stage_t s;
    s = '{valid: oValid, dmem: oDMEM, alu: oALU, i: oI, rd: oRd, wb: oWB, n: oN, z: oZ};
    return {s, oFwdHit, oFwdData};
  endfunction

  task automatic check(input string name, input logic [CMP_W-1:0] got,
                       input logic [CMP_W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] dmem,
                       input logic [DATA_W-1:0] alu, input logic [RD_W-1:0] rd,
                       input logic [WB_W-1:0] wb);
    iValid = v; iDMEM = dmem; iALU = alu; iI = alu << 4;
    iRd = rd; iWB = wb; iN = alu[0]; iZ = alu[1];
  endtask

  initial begin
    int lat;

    //            name           rst s f v  dmem    alu    rd wb     qrs  ev edmem   ealu   erd ewb    hit fd
    tbl[0]  = mk("reset",        1, 0, 0, 0, 'h0,   'h0,   0, 'h00,  0,   0, 'h0,   'h0,   0, 'h00,  0, 'h0);
    tbl[1]  = mk("drive_a",      0, 0, 0, 1, 'h0,   'h11,  5, 'h01,  5,   0, 'h0,   'h0,   0, 'h00,  1, 'h11);
    tbl[2]  = mk("a_out",        0, 0, 0, 0, 'h0,   'h0,   0, 'h00,  5,   1, 'h0,   'h11,  5, 'h01,  1, 'h11);
    tbl[3]  = mk("a_gone",       0, 0, 0, 0, 'h0,   'h0,   0, 'h00,  5,   0, 'h0,   'h0,   0, 'h00,  0, 'h0);
    tbl[4]  = mk("drive_b",      0, 0, 0, 1, 'h100, 'h21,  1, 'h01,  2,   0, 'h0,   'h0,   0, 'h00,  0, 'h0);
    tbl[5]  = mk("drive_c",      0, 0, 0, 1, 'h200, 'h22,  2, 'h03,  2,   1, 'h100, 'h21,  1, 'h01,  1, 'h200);
    tbl[6]  = mk("stall_1",      0, 1, 0, 1, 'h300, 'h23,  3, 'h01,  1,   1, 'h100, 'h21,  1, 'h01,  1, 'h21);
    tbl[7]  = mk("stall_2",      0, 1, 0, 1, 'h300, 'h23,  3, 'h01,  9,   1, 'h100, 'h21,  1, 'h01,  0, 'h0);
    tbl[8]  = mk("drive_d",      0, 0, 0, 1, 'h300, 'h23,  3, 'h01,  3,   1, 'h200, 'h22,  2, 'h03,  1, 'h23);
    tbl[9]  = mk("drive_e",      0, 0, 0, 1, 'h400, 'h24,  4, 'h00,  4,   1, 'h300, 'h23,  3, 'h01,  0, 'h0);
    tbl[10] = mk("e_out",        0, 0, 0, 0, 'h0,   'h0,   0, 'h00,  4,   1, 'h400, 'h24,  4, 'h00,  0, 'h0);
    tbl[11] = mk("drive_f",      0, 0, 0, 1, 'h500, 'h31,  6, 'h01,  0,   0, 'h0,   'h0,   0, 'h00,  0, 'h0);
    tbl[12] = mk("drive_g",      0, 0, 0, 1, 'h600, 'h32,  7, 'h01,  6,   1, 'h500, 'h31,  6, 'h01,  1, 'h31);
    tbl[13] = mk("flush_stall",  0, 1, 1, 1, 'h700, 'h33,  8, 'h01,  7,   0, 'h500, 'h31,  6, 'h00,  0, 'h0);
    tbl[14] = mk("flush_hold",   0, 0, 0, 0, 'h0,   'h0,   0, 'h00,  8,   0, 'h600, 'h32,  7, 'h00,  0, 'h0);
    tbl[15] = mk("flush_gone",   0, 0, 0, 0, 'h0,   'h0,   0, 'h00,  8,   0, 'h0,   'h0,   0, 'h00,  0, 'h0);
    tbl[16] = mk("bubble_in",    0, 0, 0, 0, 'h800, 'h41,  9, 'h7F,  9,   0, 'h0,   'h0,   0, 'h00,  0, 'h0);
    tbl[17] = mk("bubble_out",   0, 0, 0, 0, 'h0,   'h0,   0, 'h00,  9,   0, 'h800, 'h41,  9, 'h00,  0, 'h0);
    tbl[18] = mk("fwd_x",        0, 0, 0, 1, 'h0,   'hBB,  3, 'h01,  3,   0, 'h0,   'h0,   0, 'h00,  1, 'hBB);
    tbl[19] = mk("fwd_y",        0, 0, 0, 1, 'hAA,  'hCC,  3, 'h03,  3,   1, 'h0,   'hBB,  3, 'h01,  1, 'hAA);
    tbl[20] = mk("fwd_miss",     0, 1, 0, 0, 'h0,   'h0,   0, 'h00,  4,   1, 'h0,   'hBB,  3, 'h01,  0, 'h0);
    tbl[21] = mk("fwd_hit",      0, 1, 0, 0, 'h0,   'h0,   0, 'h00,  3,   1, 'h0,   'hBB,  3, 'h01,  1, 'hAA);
    tbl[22] = mk("reset_stall",  1, 1, 0, 1, 'h900, 'h55,  1, 'h01,  3,   0, 'h0,   'h0,   0, 'h00,  0, 'h0);
    tbl[23] = mk("post_reset",   0, 0, 0, 0, 'h0,   'h0,   0, 'h00,  3,   0, 'h0,   'h0,   0, 'h00,  0, 'h0);

    for (int n = 0; n < 24; n++) begin
      @(negedge clock);
      reset = tbl[n].rst; stall = tbl[n].stl; flush = tbl[n].fls; qRs = tbl[n].qrs;
      drive(tbl[n].v, tbl[n].dmem, tbl[n].alu, tbl[n].rd, tbl[n].wb);
      @(posedge clock);
      #1;
      check(tbl[n].name, observed(), expect_of(tbl[n]));
    end

    // Latency: count edges from the capturing edge until oValid rises.
    @(negedge clock);
    reset = 1'b0; stall = 1'b0; flush = 1'b0; qRs = '0;
    drive(1'b1, 'h0, 'h66, 10, 'h01);
    lat = 0;
    while (lat < 10) begin
      @(posedge clock);
      #1;
      lat++;
      drive(1'b0, 'h0, 'h0, 0, 'h00);
      if (oValid) break;
    end
    check("latency", CMP_W'(lat), CMP_W'(DEPTH));

    // Forwarding outputs must follow qRs with no clock edge in between.
    qRs = 10;
    #1;
    check("fwd_comb_hit", CMP_W'({oFwdHit, oFwdData}), CMP_W'({1'b1, 32'h66}));
    qRs = 11;
    #1;
    check("fwd_comb_miss", CMP_W'({oFwdHit, oFwdData}), CMP_W'({1'b0, 32'h0}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
